// File: rtl/bp_be_fe_cmd_buffer.sv
// bp_be_fe_cmd_buffer
//   In-order FE-command buffer between the BE director (writer) and the FE
//   command interface (reader). Commands are queued in a circular buffer and
//   presented to the FE with a valid/yumi handshake. Attaboy hints arriving
//   while the buffer is full are dropped silently. Any other command lost that
//   way sets a sticky overflow flag.
//
//   Optional feature macro: BP_BE_FE_CMD_BUFFER_STATS_EN
//     defined   -> saturating counters of enqueued commands and dropped attaboys
//     undefined -> counter ports tied to zero, no counter flops
//
// Ports
//   clk_i, reset_n_i       clock; asynchronous active-low reset
//   fe_cmd_i, fe_cmd_v_i   command from the director (no ready; writer throttles on status)
//   fe_cmd_o, fe_cmd_v_o   head-of-buffer command and its valid
//   fe_cmd_yumi_i          FE consumes the head this cycle
//   empty_n_o, full_n_o    next-cycle empty/full (combinational)
//   empty_r_o, full_r_o    current empty/full (registered)
//   overflow_o             sticky: a non-attaboy command was lost
//   attaboy_drop_cnt_o     saturating dropped-attaboy count
//   cmd_cnt_o              saturating enqueued-command count

package bp_be_fe_cmd_buffer_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int unsigned vaddr_width_gp          = 39;
  localparam int unsigned fe_cmd_operands_width_gp = 64;

  typedef enum logic [3:0] {
    e_op_state_reset          = 4'd0,
    e_op_pc_redirection       = 4'd1,
    e_op_icache_fill_response = 4'd2,
    e_op_icache_fence         = 4'd3,
    e_op_attaboy              = 4'd4,
    e_op_itlb_fill_response   = 4'd5,
    e_op_itlb_fence           = 4'd6,
    e_op_wait                 = 4'd7
  } bp_fe_command_queue_opcodes_e;

  // Opcode occupies the most significant bits of the packed command.
  typedef struct packed {
    bp_fe_command_queue_opcodes_e          opcode;
    logic [vaddr_width_gp-1:0]             npc;
    logic [fe_cmd_operands_width_gp-1:0]   operands;
  } bp_fe_cmd_s;

  localparam int unsigned opcode_width_gp = $bits(bp_fe_command_queue_opcodes_e);

  function automatic int unsigned fe_cmd_width(input bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? $bits(bp_fe_cmd_s) : $bits(bp_fe_cmd_s);
  endfunction

endpackage

module bp_be_fe_cmd_buffer
  import bp_be_fe_cmd_buffer_pkg::*;
#(
  parameter bp_params_e  bp_params_p  = e_bp_default_cfg,
  parameter int unsigned els_p        = 4,
  parameter int unsigned stat_width_p = 16,
  localparam int unsigned fe_cmd_width_lp = fe_cmd_width(bp_params_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [fe_cmd_width_lp-1:0] fe_cmd_i,
  input  logic                       fe_cmd_v_i,
  output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
  output logic                       fe_cmd_v_o,
  input  logic                       fe_cmd_yumi_i,
  output logic                       empty_n_o,
  output logic                       empty_r_o,
  output logic                       full_n_o,
  output logic                       full_r_o,
  output logic                       overflow_o,
  output logic [stat_width_p-1:0]    attaboy_drop_cnt_o,
  output logic [stat_width_p-1:0]    cmd_cnt_o
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  logic [fe_cmd_width_lp-1:0] mem [els_p];
  logic [ptr_width_lp-1:0]    rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0]    count_r, count_n;

  logic rd, wr, drop, attaboy_in;
  bp_fe_command_queue_opcodes_e opcode_in;

  assign opcode_in  = bp_fe_command_queue_opcodes_e'(fe_cmd_i[fe_cmd_width_lp-1 -: opcode_width_gp]);
  assign attaboy_in = (opcode_in == e_op_attaboy);

  assign fe_cmd_v_o = ~empty_r_o;
  assign fe_cmd_o   = mem[rd_ptr_r];

  // A write into a full buffer is only taken when the head leaves the same cycle.
  assign rd   = fe_cmd_yumi_i & fe_cmd_v_o;
  assign wr   = fe_cmd_v_i & (~full_r_o | rd);
  assign drop = fe_cmd_v_i & full_r_o & ~rd;

  assign count_n   = count_r + cnt_width_lp'(wr) - cnt_width_lp'(rd);
  assign empty_n_o = (count_n == '0);
  assign full_n_o  = (count_n == cnt_width_lp'(els_p));

  // Storage is intentionally not reset; the head is don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr_r] <= fe_cmd_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      empty_r_o  <= 1'b1;
      full_r_o   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (wr) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      if (rd) rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
      count_r   <= count_n;
      empty_r_o <= empty_n_o;
      full_r_o  <= full_n_o;
      if (drop & ~attaboy_in) overflow_o <= 1'b1;
    end
  end

`ifdef BP_BE_FE_CMD_BUFFER_STATS_EN
  logic [stat_width_p-1:0] cmd_cnt_r, attaboy_drop_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_cnt_r          <= '0;
      attaboy_drop_cnt_r <= '0;
    end else begin
      if (wr && (cmd_cnt_r != '1))
        cmd_cnt_r <= cmd_cnt_r + stat_width_p'(1);
      if (drop && attaboy_in && (attaboy_drop_cnt_r != '1))
        attaboy_drop_cnt_r <= attaboy_drop_cnt_r + stat_width_p'(1);
    end
  end

  assign cmd_cnt_o          = cmd_cnt_r;
  assign attaboy_drop_cnt_o = attaboy_drop_cnt_r;
`else
  assign cmd_cnt_o          = '0;
  assign attaboy_drop_cnt_o = '0;
`endif

endmodule
